// File: rtl/lsu_if.sv
// Request/response handshake and word-memory port between the pipeline, the LSU and the data memory.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Pipeline and memory side.
  modport master (
    output req_valid, req_is_store, req_type, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  // LSU side.
  modport slave (
    input  req_valid, req_is_store, req_type, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses on a word-wide memory, including accesses that
// straddle two words, done as read-modify-write sequences through a small FSM.
module lsu (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP} state_t;

  state_t      state, state_nxt;
  logic        is_store_q;
  logic [2:0]  type_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_buf, hi_buf;

  function automatic logic is_illegal(input logic st, input logic [2:0] t);
    if (st) return t > 3'd2;
    return (t == 3'd3) || (t > 3'd5);
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic spans(input logic [1:0] off, input logic [2:0] t);
    return ({1'b0, off} + size_of(t)) > 3'd4;
  endfunction

  logic [1:0]  offset;
  logic [4:0]  bit_shift;
  logic [13:0] lo_idx, hi_idx;
  logic        span_q, illegal_q;
  logic [63:0] pair, byte_mask, mask_sh, wd_sh, merged;
  logic [31:0] load_raw, load_ext;

  assign offset    = addr_q[1:0];
  assign bit_shift = {offset, 3'b000};
  assign lo_idx    = addr_q[15:2];
  assign hi_idx    = lo_idx + 14'd1;  // wraps 0x3FFF -> 0x0000
  assign span_q    = spans(offset, type_q);
  assign illegal_q = is_illegal(is_store_q, type_q);
  assign pair      = {hi_buf, lo_buf};

  always_comb begin
    case (type_q[1:0])
      2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
      2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
      default: byte_mask = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  // Stores splice the new bytes into the two-word window; loads shift it down and extend.
  assign mask_sh  = byte_mask << bit_shift;
  assign wd_sh    = {32'd0, wdata_q} << bit_shift;
  assign merged   = (pair & ~mask_sh) | (wd_sh & mask_sh);
  assign load_raw = 32'(pair >> bit_shift);

  always_comb begin
    case (type_q)
      3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
      3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
      3'b100:  load_ext = {24'd0, load_raw[7:0]};
      3'b101:  load_ext = {16'd0, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (latch).
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = 14'd0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 32'd0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (is_illegal(bus.req_is_store, bus.req_type))
            state_nxt = RESP;
          else if (bus.req_is_store && bus.req_type == 3'b010 && bus.req_addr[1:0] == 2'b00)
            state_nxt = WR_LO;
          else
            state_nxt = RD_LO;
        end
      end
      RD_LO: begin
        bus.mem_addr = lo_idx;
        if (span_q)          state_nxt = RD_HI;
        else if (is_store_q) state_nxt = WR_LO;
        else                 state_nxt = RESP;
      end
      RD_HI: begin
        bus.mem_addr = hi_idx;
        state_nxt    = is_store_q ? WR_LO : RESP;
      end
      WR_LO: begin
        bus.mem_addr  = lo_idx;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged[31:0];
        state_nxt     = span_q ? WR_HI : RESP;
      end
      WR_HI: begin
        bus.mem_addr  = hi_idx;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged[63:32];
        state_nxt     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = illegal_q;
        bus.resp_rdata = (is_store_q || illegal_q) ? 32'd0 : load_ext;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      type_q     <= 3'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 32'd0;
      lo_buf     <= 32'd0;
      hi_buf     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        is_store_q <= bus.req_is_store;
        type_q     <= bus.req_type;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
      end
      if (state == RD_LO) lo_buf <= bus.mem_rdata;
      if (state == RD_HI) hi_buf <= bus.mem_rdata;
    end
  end

endmodule
